// File: rtl/reg_issue_decode.sv
// SLC3-M register decode/issue stage with per-register outstanding-write scoreboard.
// Optional RAW_BYPASS_EN lets a source whose last write retires this cycle count as free.
module reg_issue_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic             one,
    output logic             under
);
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            cnt <= '0;
        else if (inc && !dec)
            cnt <= cnt + CNT_W'(1);
        else if (dec && !inc && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign sat   = &cnt;
    assign one   = (cnt == CNT_W'(1));
    // A same-cycle issue to this register absorbs the retirement, so no underflow.
    assign under = dec && !inc && (cnt == '0);
endmodule

module reg_issue_decode #(
    parameter int CNT_W      = 2,
    parameter bit IMM_DECODE = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ir_valid,
    input  logic [15:0] IR,
    output logic        ir_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  DR,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic        dr_we,
    output logic        sr1_re,
    output logic        sr2_re,
    output logic [3:0]  opcode,
    input  logic        wb_valid,
    input  logic [2:0]  wb_addr,
    output logic [7:0]  busy,
    output logic        wb_err
);
    localparam int NREG = 8;

    logic [2:0] d_dr, d_sr1, d_sr2;
    logic       d_we, d_re1, d_re2;
    logic       hazard, accept;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            inc, dec, sat, one, under, busy_eff;

    logic unused_ir;
    assign unused_ir = ^IR[4:3];

    always_comb begin
        d_dr  = '0;
        d_sr1 = '0;
        d_sr2 = '0;
        d_we  = 1'b0;
        d_re1 = 1'b0;
        d_re2 = 1'b0;
        case (IR[15:12])
            4'b0001, 4'b0101, 4'b1111, 4'b1010, 4'b1011: begin
                d_dr  = IR[11:9];
                d_we  = 1'b1;
                d_sr1 = IR[8:6];
                d_re1 = 1'b1;
                d_sr2 = IR[2:0];
                d_re2 = !(IMM_DECODE && IR[5]);
            end
            4'b1001: begin
                d_dr  = IR[11:9];
                d_we  = 1'b1;
                d_sr1 = IR[8:6];
                d_re1 = 1'b1;
            end
            4'b0010, 4'b1110: begin
                d_dr = IR[11:9];
                d_we = 1'b1;
            end
            4'b0011: begin
                d_sr1 = IR[11:9];
                d_re1 = 1'b1;
            end
            4'b0110: begin
                d_dr  = IR[11:9];
                d_we  = 1'b1;
                d_sr2 = IR[8:6];
                d_re2 = 1'b1;
            end
            4'b0111: begin
                d_sr1 = IR[11:9];
                d_re1 = 1'b1;
                d_sr2 = IR[8:6];
                d_re2 = 1'b1;
            end
            4'b1100: begin
                d_sr2 = IR[8:6];
                d_re2 = 1'b1;
            end
            4'b0100: begin
                d_dr = 3'd7;
                d_we = 1'b1;
                if (!IR[11]) begin
                    d_sr2 = IR[8:6];
                    d_re2 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    genvar r;
    generate
        for (r = 0; r < NREG; r++) begin : g_reg
            assign inc[r] = accept && d_we && (d_dr == 3'(r));
            assign dec[r] = wb_valid && (wb_addr == 3'(r));
            assign busy[r] = (cnt[r] != '0);
`ifdef RAW_BYPASS_EN
            assign busy_eff[r] = busy[r] && !(dec[r] && one[r]);
`else
            assign busy_eff[r] = busy[r];
`endif
            reg_issue_cnt #(.CNT_W(CNT_W)) u_cnt (
                .Clk   (Clk),
                .Reset (Reset),
                .inc   (inc[r]),
                .dec   (dec[r]),
                .cnt   (cnt[r]),
                .sat   (sat[r]),
                .one   (one[r]),
                .under (under[r])
            );
        end
    endgenerate

    logic unused_one;
    assign unused_one = ^one;

    // Saturation is judged on the registered count only; a retirement frees it next cycle.
    assign hazard   = (d_re1 && busy_eff[d_sr1]) || (d_re2 && busy_eff[d_sr2]) ||
                      (d_we && sat[d_dr]);
    assign ir_ready = !Reset && (!out_valid || out_ready) && !hazard;
    assign accept   = ir_valid && ir_ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            DR        <= '0;
            SR1       <= '0;
            SR2       <= '0;
            dr_we     <= 1'b0;
            sr1_re    <= 1'b0;
            sr2_re    <= 1'b0;
            opcode    <= '0;
            wb_err    <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                DR        <= d_dr;
                SR1       <= d_sr1;
                SR2       <= d_sr2;
                dr_we     <= d_we;
                sr1_re    <= d_re1;
                sr2_re    <= d_re2;
                opcode    <= IR[15:12];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (|under)
                wb_err <= 1'b1;
        end
    end
endmodule

// File: doc/reg_issue_decode.md
# reg_issue_decode

Register-address decode and issue stage for the SLC3-M datapath, with per-register hazard tracking. Accepts an instruction word from fetch over a valid/ready handshake, decodes destination/source register addresses plus read/write enables, and holds issue while any source register or the destination counter is busy with an outstanding write. Sits between the IR register and the register file/execute stage; writeback retirements from execute clear the scoreboard.

## Interface
- CNT_W, 2, width of the per-register outstanding-write counter; up to 2^CNT_W-1 in-flight writes per register
- IMM_DECODE, 1, 1: IR[5]=1 on ADD/AND/SUB/MULT/DIV means immediate, SR2 not read; 0: SR2 always read on those ops

- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- ir_valid  in  1  IR holds a valid instruction
- IR  in  16  instruction word
- ir_ready  out  1  stage accepts IR this cycle
- out_valid  out  1  decoded instruction present
- out_ready  in  1  execute consumes decoded instruction
- DR, SR1, SR2  out  3 each  decoded register addresses
- dr_we, sr1_re, sr2_re  out  1 each  write/read enables for those addresses
- opcode  out  4  IR[15:12] of the held instruction
- wb_valid  in  1  execute retires one register write
- wb_addr  in  3  register retired
- busy  out  8  bit r = counter r nonzero
- wb_err  out  1  sticky: retirement to a register with zero count

## Operation
- Decode (address, enable); unlisted fields 0, enables 0:
  - ADD 0001, AND 0101, SUB 1111, MULT 1010, DIV 1011: DR=IR[11:9] we; SR1=IR[8:6] re; SR2=IR[2:0], re unless IMM_DECODE and IR[5]
  - NOT 1001: DR we, SR1=IR[8:6] re
  - LD 0010, LEA 1110: DR=IR[11:9] we
  - ST 0011: SR1=IR[11:9] re
  - LDR 0110: DR=IR[11:9] we; SR2=IR[8:6] re
  - STR 0111: SR1=IR[11:9] re; SR2=IR[8:6] re
  - JMP 1100: SR2=IR[8:6] re
  - JSR 0100: DR=7 we; if IR[11]=0 also SR2=IR[8:6] re
  - BR 0000, others: no register activity
- Hazard: any enabled source with busy set, or dr_we with DR counter at 2^CNT_W-1.
- ir_ready = !Reset && (!out_valid || out_ready) && !hazard.
- Accept (ir_valid && ir_ready): output register loads decode, out_valid=1; if dr_we, counter[DR] +1.
- out_valid && out_ready without accept: out_valid=0; address/enable fields hold.
- Retire (wb_valid): counter[wb_addr] -1; count 0 -> no change, wb_err=1 until Reset.
- Accept increment and retire on same register same cycle: net unchanged (no error even at count 0).

## Timing
- Reset: out_valid, DR, SR1, SR2, enables, opcode, busy, wb_err = 0; all counters 0; ir_ready=0 while Reset high.
- Latency: accept in cycle N -> out_valid, fields valid from cycle N+1.
- Full throughput: back-to-back independent instructions issue one per cycle with out_ready=1.
- Scoreboard update visible to hazard check the cycle after accept; an instruction reading the previous one's DR stalls until that write retires.
- Reset mid-stall or mid-transfer: held instruction discarded, counters cleared; outstanding writebacks arriving after reset set wb_err.

## Configuration
- RAW_BYPASS_EN defined: hazard check treats a source as free when wb_valid targets it and its count is 1 in the same cycle; dependent instruction accepted in the retirement cycle.
- Undefined: hazard uses registered counters only; dependent instruction accepted one cycle after retirement.

## Test plan
- Reset released, ir_valid with 0x1283 (ADD R1,R2,R3) -> next cycle DR=1, SR1=2, SR2=3, all enables 1, busy=0x02.
- 0x1283 then 0x1861 (ADD R4,R1,#1) -> second stalls (ir_ready=0), sr2_re=0 on issue; wb_addr=1 releases it: same cycle with RAW_BYPASS_EN, next cycle without.
- Three writes to R1 with CNT_W=2, no retirement -> fourth 0x1283 stalls on DR saturation until one wb_valid to R1.
- out_ready=0 with out_valid=1 -> ir_ready=0, fields stable; out_ready=1 -> accept resumes.
- wb_valid to R5 with count 0 -> wb_err=1, stays 1 until Reset.
- JSR 0x4000 (JSRR R0) -> DR=7 dr_we=1, SR2=0 sr2_re=1; JSR 0x4800 -> sr2_re=0.
